// File: rtl/calc3_pkg.sv
// Shared calc3 definitions: command encodings, command classification, default sizing.
package calc3_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_TAG_W     = 2;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_INVALID = 2'd2;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_ADD,
        CLS_SHF,
        CLS_INV
    } cmd_class_e;

    function automatic cmd_class_e cmd_class(input logic [3:0] cmd);
        cmd_class_e cls;
        case (cmd)
            CMD_NOP:          cls = CLS_NONE;
            CMD_ADD, CMD_SUB: cls = CLS_ADD;
            CMD_SHL, CMD_SHR: cls = CLS_SHF;
            default:          cls = CLS_INV;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: the search starts at ptr and wraps 3->0.
// A constant ptr of 0 turns it into a fixed port-0-first priority picker.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    // Walk from the farthest offset down so the nearest requester to ptr is written last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                gnt = 4'b0001 << cand;
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_dispatch_arb.sv
// Dispatches held port requests to the adder and shifter, tracks in-flight tags, answers invalid commands.
// Build with ARB_FIXED_PRIO_EN for fixed port-0-first priority instead of round-robin.
module prio_dispatch_arb
    import calc3_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic                       c_clk,
    input  logic                       reset,
    input  logic [4*NUM_PORTS-1:0]     hold_prio_req,
    input  logic [TAG_W*NUM_PORTS-1:0] hold_prio_tag,
    output logic [NUM_PORTS-1:0]       port_ack,
    output logic                       add_vld,
    output logic [1:0]                 add_port,
    output logic [TAG_W-1:0]           add_tag,
    output logic [3:0]                 add_cmd,
    output logic                       shf_vld,
    output logic [1:0]                 shf_port,
    output logic [TAG_W-1:0]           shf_tag,
    output logic [3:0]                 shf_cmd,
    input  logic [1:0]                 cmpl_vld,
    input  logic [3:0]                 cmpl_port,
    input  logic [2*TAG_W-1:0]         cmpl_tag,
    output logic                       err_vld,
    output logic [1:0]                 err_port,
    output logic [TAG_W-1:0]           err_tag
);

    localparam int NTAGS = 1 << TAG_W;

    logic [NUM_PORTS-1:0][NTAGS-1:0] sb, sb_nxt;
    logic                            sb_err, sb_err_nxt;

    logic [NUM_PORTS-1:0] add_req, shf_req, inv_gnt;
    logic [NUM_PORTS-1:0] add_gnt, shf_gnt;
    logic [1:0]           add_idx, shf_idx, inv_idx;
    logic [1:0]           add_ptr, shf_ptr;
    logic                 add_any, shf_any, inv_any;
    logic [3:0]           add_win_cmd, shf_win_cmd;
    logic [TAG_W-1:0]     add_win_tag, shf_win_tag, inv_win_tag;

    // A port acked last cycle still shows its consumed request, so port_ack masks it.
    always_comb begin : classify
        logic [3:0]       c;
        logic [TAG_W-1:0] t;
        logic             free;
        add_req = '0;
        shf_req = '0;
        inv_gnt = '0;
        inv_idx = '0;
        inv_any = 1'b0;
        c       = '0;
        t       = '0;
        free    = 1'b0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            c    = hold_prio_req[4*p +: 4];
            t    = hold_prio_tag[TAG_W*p +: TAG_W];
            free = !port_ack[p] && !sb[p][t];
            case (cmd_class(c))
                CLS_ADD: add_req[p] = free;
                CLS_SHF: shf_req[p] = free;
                CLS_INV: begin
                    if (free) begin
                        inv_any = 1'b1;
                        inv_idx = 2'(p);
                        inv_gnt = NUM_PORTS'(1) << p;
                    end
                end
                default: ;
            endcase
        end
    end

    rr_pick4 u_add_pick (
        .req (add_req),
        .ptr (add_ptr),
        .gnt (add_gnt),
        .idx (add_idx),
        .any (add_any)
    );

    rr_pick4 u_shf_pick (
        .req (shf_req),
        .ptr (shf_ptr),
        .gnt (shf_gnt),
        .idx (shf_idx),
        .any (shf_any)
    );

    assign add_win_cmd = hold_prio_req[4*add_idx +: 4];
    assign shf_win_cmd = hold_prio_req[4*shf_idx +: 4];
    assign add_win_tag = hold_prio_tag[TAG_W*add_idx +: TAG_W];
    assign shf_win_tag = hold_prio_tag[TAG_W*shf_idx +: TAG_W];
    assign inv_win_tag = hold_prio_tag[TAG_W*inv_idx +: TAG_W];

`ifdef ARB_FIXED_PRIO_EN
    assign add_ptr = '0;
    assign shf_ptr = '0;
`else
    always_ff @(negedge c_clk or posedge reset) begin
        if (reset) begin
            add_ptr <= '0;
            shf_ptr <= '0;
        end else begin
            if (add_any) add_ptr <= add_idx + 2'd1;
            if (shf_any) shf_ptr <= shf_idx + 2'd1;
        end
    end
`endif

    // Clears retire the old op first; a same-bit set from a new dispatch then wins.
    always_comb begin
        sb_nxt     = sb;
        sb_err_nxt = sb_err;
        for (int u = 0; u < 2; u++) begin
            if (cmpl_vld[u]) begin
                if (!sb[cmpl_port[2*u +: 2]][cmpl_tag[TAG_W*u +: TAG_W]]) sb_err_nxt = 1'b1;
                sb_nxt[cmpl_port[2*u +: 2]][cmpl_tag[TAG_W*u +: TAG_W]] = 1'b0;
            end
        end
        if (add_any) sb_nxt[add_idx][add_win_tag] = 1'b1;
        if (shf_any) sb_nxt[shf_idx][shf_win_tag] = 1'b1;
    end

    always_ff @(negedge c_clk or posedge reset) begin
        if (reset) begin
            sb       <= '0;
            sb_err   <= 1'b0;
            port_ack <= '0;
            add_vld  <= 1'b0;
            add_port <= '0;
            add_tag  <= '0;
            add_cmd  <= CMD_NOP;
            shf_vld  <= 1'b0;
            shf_port <= '0;
            shf_tag  <= '0;
            shf_cmd  <= CMD_NOP;
            err_vld  <= 1'b0;
            err_port <= '0;
            err_tag  <= '0;
        end else begin
            sb       <= sb_nxt;
            sb_err   <= sb_err_nxt;
            port_ack <= add_gnt | shf_gnt | inv_gnt;
            add_vld  <= add_any;
            add_port <= add_any ? add_idx : 2'd0;
            add_tag  <= add_any ? add_win_tag : '0;
            add_cmd  <= add_any ? add_win_cmd : CMD_NOP;
            shf_vld  <= shf_any;
            shf_port <= shf_any ? shf_idx : 2'd0;
            shf_tag  <= shf_any ? shf_win_tag : '0;
            shf_cmd  <= shf_any ? shf_win_cmd : CMD_NOP;
            err_vld  <= inv_any;
            err_port <= inv_idx;
            err_tag  <= inv_any ? inv_win_tag : '0;
        end
    end

endmodule

// File: tb/tb_prio_dispatch_arb.sv
// Directed bench for prio_dispatch_arb with a per-cycle reference model; honours ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps
module tb_prio_dispatch_arb;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_cmd [4];
    logic [1:0]  req_tag [4];
    logic [15:0] hold_prio_req;
    logic [7:0]  hold_prio_tag;
    logic [1:0]  cmpl_vld  = '0;
    logic [3:0]  cmpl_port = '0;
    logic [3:0]  cmpl_tag  = '0;

    logic [3:0] port_ack;
    logic       add_vld, shf_vld, err_vld;
    logic [1:0] add_port, shf_port, err_port;
    logic [1:0] add_tag, shf_tag, err_tag;
    logic [3:0] add_cmd, shf_cmd;

    assign hold_prio_req = {req_cmd[3], req_cmd[2], req_cmd[1], req_cmd[0]};
    assign hold_prio_tag = {req_tag[3], req_tag[2], req_tag[1], req_tag[0]};

    prio_dispatch_arb dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .hold_prio_req (hold_prio_req),
        .hold_prio_tag (hold_prio_tag),
        .port_ack      (port_ack),
        .add_vld       (add_vld),
        .add_port      (add_port),
        .add_tag       (add_tag),
        .add_cmd       (add_cmd),
        .shf_vld       (shf_vld),
        .shf_port      (shf_port),
        .shf_tag       (shf_tag),
        .shf_cmd       (shf_cmd),
        .cmpl_vld      (cmpl_vld),
        .cmpl_port     (cmpl_port),
        .cmpl_tag      (cmpl_tag),
        .err_vld       (err_vld),
        .err_port      (err_port),
        .err_tag       (err_tag)
    );

    always #5 c_clk = ~c_clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en    = 1'b0;
    bit auto_cmpl = 1'b0;

    // Reference model state: outstanding tags, rotation pointers, expected outputs.
    bit         mo [4][4];
    int         m_add_ptr, m_shf_ptr;
    logic [3:0] exp_ack;
    logic       exp_add_vld, exp_shf_vld, exp_err_vld;
    logic [1:0] exp_add_port, exp_shf_port, exp_err_port;
    logic [1:0] exp_add_tag, exp_shf_tag, exp_err_tag;
    logic [3:0] exp_add_cmd, exp_shf_cmd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int cls(input logic [3:0] c);
        if (c == 4'd0) return 0;
        if (c == 4'd1 || c == 4'd2) return 1;
        if (c == 4'd5 || c == 4'd6) return 2;
        return 3;
    endfunction

    task automatic clear_exp();
        exp_ack = '0;
        exp_add_vld = 1'b0; exp_add_port = '0; exp_add_tag = '0; exp_add_cmd = '0;
        exp_shf_vld = 1'b0; exp_shf_port = '0; exp_shf_tag = '0; exp_shf_cmd = '0;
        exp_err_vld = 1'b0; exp_err_port = '0; exp_err_tag = '0;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++)
            for (int t = 0; t < 4; t++) mo[p][t] = 1'b0;
        m_add_ptr = 0;
        m_shf_ptr = 0;
        clear_exp();
    endtask

    // One arbitration step as seen at a falling edge.
    task automatic model_step();
        int aw = -1;
        int sw = -1;
        int iw = -1;
        int p;
        logic [3:0] busy;
        busy = exp_ack;
        for (int k = 0; k < 4; k++) begin
            p = (m_add_ptr + k) % 4;
            if (aw < 0 && cls(req_cmd[p]) == 1 && !busy[p] && !mo[p][req_tag[p]]) aw = p;
            p = (m_shf_ptr + k) % 4;
            if (sw < 0 && cls(req_cmd[p]) == 2 && !busy[p] && !mo[p][req_tag[p]]) sw = p;
            if (iw < 0 && cls(req_cmd[k]) == 3 && !busy[k] && !mo[k][req_tag[k]]) iw = k;
        end
        if (cmpl_vld[0]) mo[cmpl_port[1:0]][cmpl_tag[1:0]] = 1'b0;
        if (cmpl_vld[1]) mo[cmpl_port[3:2]][cmpl_tag[3:2]] = 1'b0;
        clear_exp();
        if (aw >= 0) begin
            exp_add_vld = 1'b1; exp_add_port = 2'(aw);
            exp_add_tag = req_tag[aw]; exp_add_cmd = req_cmd[aw];
            exp_ack[aw] = 1'b1; mo[aw][req_tag[aw]] = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
            m_add_ptr = (aw + 1) % 4;
`endif
        end
        if (sw >= 0) begin
            exp_shf_vld = 1'b1; exp_shf_port = 2'(sw);
            exp_shf_tag = req_tag[sw]; exp_shf_cmd = req_cmd[sw];
            exp_ack[sw] = 1'b1; mo[sw][req_tag[sw]] = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
            m_shf_ptr = (sw + 1) % 4;
`endif
        end
        if (iw >= 0) begin
            exp_err_vld = 1'b1; exp_err_port = 2'(iw);
            exp_err_tag = req_tag[iw]; exp_ack[iw] = 1'b1;
        end
    endtask

    always @(posedge c_clk) begin
        if (chk_en) begin
            chk("port_ack", 32'(port_ack), 32'(exp_ack));
            chk("add_vld",  32'(add_vld),  32'(exp_add_vld));
            chk("add_port", 32'(add_port), 32'(exp_add_port));
            chk("add_tag",  32'(add_tag),  32'(exp_add_tag));
            chk("add_cmd",  32'(add_cmd),  32'(exp_add_cmd));
            chk("shf_vld",  32'(shf_vld),  32'(exp_shf_vld));
            chk("shf_port", 32'(shf_port), 32'(exp_shf_port));
            chk("shf_tag",  32'(shf_tag),  32'(exp_shf_tag));
            chk("shf_cmd",  32'(shf_cmd),  32'(exp_shf_cmd));
            chk("err_vld",  32'(err_vld),  32'(exp_err_vld));
            chk("err_port", 32'(err_port), 32'(exp_err_port));
            chk("err_tag",  32'(err_tag),  32'(exp_err_tag));
        end
    end

    task automatic set_req(input int p, input logic [3:0] c, input logic [1:0] t);
        req_cmd[p] = c;
        req_tag[p] = t;
    endtask

    task automatic clr_reqs();
        for (int p = 0; p < 4; p++) set_req(p, 4'd0, 2'd0);
    endtask

    task automatic set_cmpl(input logic [1:0] v, input logic [3:0] prt, input logic [3:0] tg);
        cmpl_vld  = v;
        cmpl_port = prt;
        cmpl_tag  = tg;
    endtask

    // Advance one cycle; inputs for the next cycle are driven after return.
    task automatic tick();
        @(negedge c_clk); #1;
        model_step();
        @(posedge c_clk); #1;
        if (auto_cmpl)
            set_cmpl({exp_shf_vld, exp_add_vld}, {exp_shf_port, exp_add_port},
                     {exp_shf_tag, exp_add_tag});
        else
            set_cmpl(2'b00, 4'd0, 4'd0);
    endtask

    int seq1 [5];
    int seq6 [6] = '{0, 2, 0, 2, 0, 2};

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        seq1 = '{0, 1, 0, 1, 0};
`else
        seq1 = '{0, 1, 2, 3, 0};
`endif
        clr_reqs();
        model_reset();
        #2;
        chk("rst_add_vld",  32'(add_vld),  32'd0);
        chk("rst_shf_vld",  32'(shf_vld),  32'd0);
        chk("rst_err_vld",  32'(err_vld),  32'd0);
        chk("rst_port_ack", 32'(port_ack), 32'd0);
        @(posedge c_clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // All ports hammer the adder with tag 0; each op retires the next cycle.
        auto_cmpl = 1'b1;
        for (int p = 0; p < 4; p++) set_req(p, 4'd1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_add_vld",  32'(add_vld),  32'd1);
            chk("t1_add_port", 32'(add_port), 32'(seq1[i]));
            chk("t1_ack",      32'(port_ack), 32'(4'b0001 << seq1[i]));
            chk("t1_shf_vld",  32'(shf_vld),  32'd0);
        end
        clr_reqs();
        tick(); tick();

        // Adder and shifter dispatch in the same cycle.
        set_req(0, 4'd1, 2'd1);
        set_req(1, 4'd5, 2'd1);
        tick();
        chk("t2_add_port", 32'(add_port), 32'd0);
        chk("t2_add_tag",  32'(add_tag),  32'd1);
        chk("t2_shf_vld",  32'(shf_vld),  32'd1);
        chk("t2_shf_port", 32'(shf_port), 32'd1);
        chk("t2_shf_cmd",  32'(shf_cmd),  32'd5);
        chk("t2_ack",      32'(port_ack), 32'b0011);
        clr_reqs();
        tick(); tick();

        // Tag reuse stalls until its completion has been sampled.
        auto_cmpl = 1'b0;
        set_req(2, 4'd2, 2'd3);
        tick();
        chk("t3_first_vld",  32'(add_vld),  32'd1);
        chk("t3_first_port", 32'(add_port), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall_ack", 32'(port_ack), 32'd0);
            chk("t3_stall_vld", 32'(add_vld),  32'd0);
        end
        set_cmpl(2'b01, 4'b0010, 4'b0011);
        tick();
        chk("t3_cmpl_cycle_vld", 32'(add_vld), 32'd0);
        tick();
        chk("t3_redisp_vld", 32'(add_vld),  32'd1);
        chk("t3_redisp_tag", 32'(add_tag),  32'd3);
        chk("t3_redisp_ack", 32'(port_ack), 32'b0100);
        clr_reqs();
        set_cmpl(2'b01, 4'b0010, 4'b0011);
        tick(); tick();

        // Stray completion on a clear bit alongside a dispatch of that bit: the set wins.
        set_req(0, 4'd1, 2'd2);
        set_cmpl(2'b01, 4'b0000, 4'b0010);
        tick();
        chk("sc_disp_vld", 32'(add_vld), 32'd1);
        tick(); tick();
        chk("sc_still_set", 32'(port_ack), 32'd0);
        clr_reqs();
        set_cmpl(2'b01, 4'b0000, 4'b0010);
        tick(); tick();

        // Invalid commands are answered directly, lowest port first.
        set_req(3, 4'b0011, 2'd2);
        tick();
        chk("t4_err_vld",  32'(err_vld),  32'd1);
        chk("t4_err_port", 32'(err_port), 32'd3);
        chk("t4_err_tag",  32'(err_tag),  32'd2);
        chk("t4_ack",      32'(port_ack), 32'b1000);
        chk("t4_add_vld",  32'(add_vld),  32'd0);
        set_req(3, 4'd1, 2'd2);
        tick();
        tick();
        chk("t4_sb_untouched", 32'(add_port), 32'd3);
        clr_reqs();
        set_cmpl(2'b01, 4'b0011, 4'b0010);
        tick();
        set_req(1, 4'd7, 2'd0);
        set_req(3, 4'd15, 2'd1);
        tick();
        chk("t4_two_inv_a", 32'(err_port), 32'd1);
        tick();
        chk("t4_two_inv_b", 32'(err_port), 32'd3);
        clr_reqs();
        tick(); tick();

        // Reset with three tags in flight.
        set_req(0, 4'd1, 2'd0);
        set_req(1, 4'd5, 2'd1);
        set_req(2, 4'd1, 2'd2);
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_add_vld", 32'(add_vld),  32'd0);
        chk("t5_rst_ack",     32'(port_ack), 32'd0);
        chk("t5_rst_shf_vld", 32'(shf_vld),  32'd0);
        model_reset();
        set_cmpl(2'b11, 4'b0100, 4'b0100);
        @(negedge c_clk);
        @(posedge c_clk); #1;
        set_cmpl(2'b00, 4'd0, 4'd0);
        reset = 1'b0;
        tick();
        chk("t5_reissue_add",  32'(add_port), 32'd0);
        chk("t5_reissue_shf",  32'(shf_vld),  32'd1);
        chk("t5_reissue_ack",  32'(port_ack), 32'b0011);
        tick();
        chk("t5_reissue_add2", 32'(add_port), 32'd2);
        clr_reqs();
        set_cmpl(2'b11, 4'b0100, 4'b0100);
        tick();
        set_cmpl(2'b01, 4'b0010, 4'b0010);
        tick(); tick();

        // Two ports contend for the adder continuously.
        auto_cmpl = 1'b1;
        set_req(0, 4'd2, 2'd1);
        set_req(2, 4'd2, 2'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_add_port", 32'(add_port), 32'(seq6[i]));
        end
        clr_reqs();
        tick(); tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
